// File: rtl/mem_requester_pkg.sv
// Shared types for the main-memory requester: access sizes, FSM states and
// the memory access-type encoding, plus small decode helpers.
package mem_requester_pkg;

    typedef enum logic [1:0] {
        LssByte = 2'd0,
        LssHalf = 2'd1,
        LssWord = 2'd2
    } ls_size_e;

    typedef enum logic [2:0] {
        Idle,
        IfRd,
        LsRd,
        RmwRd,
        RmwWr,
        LsWr,
        Resp,
        Reject
    } mem_req_state_e;

    typedef enum logic {
        DiatRead  = 1'b0,
        DiatWrite = 1'b1
    } data_inout_access_type_e;

    // Encoding 3 has no size of its own and behaves as a word access.
    function automatic ls_size_e decode_size(input logic [1:0] raw);
        return (raw == 2'd3) ? LssWord : ls_size_e'(raw);
    endfunction

    function automatic logic is_misaligned(input ls_size_e size, input logic [1:0] offset);
        case (size)
            LssHalf: return offset[0];
            LssWord: return offset != 2'd0;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_requester_lane_steer.sv
// Big-endian lane steering: extracts a zero-extended byte/half/word from a
// memory word, and merges right-justified store data into that word.
module mem_lane_steer
    import mem_requester_pkg::*;
(
    input  ls_size_e    size,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_value,
    output logic [31:0] merged_word
);

    int lsb;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave a value held and infer a latch.
    always_comb begin
        load_value  = '0;
        merged_word = word;
        lsb         = 0;
        case (size)
            LssByte: begin
                lsb                     = 8 * (3 - int'(offset));
                load_value[7:0]         = word[lsb +: 8];
                merged_word[lsb +: 8]   = wdata[7:0];
            end
            LssHalf: begin
                lsb                     = offset[1] ? 0 : 16;
                load_value[15:0]        = word[lsb +: 16];
                merged_word[lsb +: 16]  = wdata[15:0];
            end
            default: begin
                load_value  = word;
                merged_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_requester.sv
// Main-memory initiator arbitrating instruction fetch and load/store clients;
// sub-word stores are performed as read-modify-write of the containing word.
module mem_requester
    import mem_requester_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [1:0]            ls_size,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_done,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic                  ls_misaligned,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_access_type,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_wait
);

    mem_req_state_e          state, next_state;
    data_inout_access_type_e access_type;

    logic [ADDR_WIDTH-1:0] addr_q;
    ls_size_e              size_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  client_if_q;
    logic [DATA_WIDTH-1:0] if_rdata_q;
    logic [DATA_WIDTH-1:0] ls_rdata_q;

    logic [DATA_WIDTH-1:0] load_value;
    logic [DATA_WIDTH-1:0] merged_word;

    ls_size_e in_size;
    logic     in_misaligned;
    logic     take_ls;
    logic     take_if;

    assign in_size       = decode_size(ls_size);
    assign in_misaligned = is_misaligned(in_size, ls_addr[1:0]);
    assign take_ls       = ls_req && (DATA_FIRST || !if_req);
    assign take_if       = if_req && !take_ls;

    mem_lane_steer u_lane_steer (
        .size        (size_q),
        .offset      (addr_q[1:0]),
        .word        (mem_rdata),
        .wdata       (wdata_q),
        .load_value  (load_value),
        .merged_word (merged_word)
    );

    // NOTE: registers use non-blocking assignment so every flop samples the
    // pre-edge values, independent of the order the always blocks evaluate.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= Idle;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            Idle: begin
                if (take_ls) begin
                    if (in_misaligned)           next_state = Reject;
                    else if (!ls_we)             next_state = LsRd;
                    else if (in_size == LssWord) next_state = LsWr;
                    else                         next_state = RmwRd;
                end else if (take_if) begin
                    next_state = IfRd;
                end
            end
            IfRd, LsRd:   if (!mem_wait) next_state = Resp;
            RmwRd:        if (!mem_wait) next_state = RmwWr;
            RmwWr, LsWr:  next_state = Resp;
            Resp, Reject: next_state = Idle;
            default:      next_state = Idle;
        endcase
    end

    // Request parameters are frozen on the Idle exit edge; a stalled read
    // therefore keeps every mem_* output stable until it completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            size_q      <= LssByte;
            wdata_q     <= '0;
            client_if_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            if (state == Idle) begin
                if (take_ls) begin
                    addr_q      <= ls_addr;
                    size_q      <= in_size;
                    wdata_q     <= ls_wdata;
                    client_if_q <= 1'b0;
                end else if (take_if) begin
                    addr_q      <= if_addr;
                    size_q      <= LssWord;
                    client_if_q <= 1'b1;
                end
            end
            if (!mem_wait) begin
                if (state == IfRd)  if_rdata_q <= mem_rdata;
                if (state == LsRd)  ls_rdata_q <= load_value;
                if (state == RmwRd) wdata_q    <= merged_word;
            end
        end
    end

    always_comb begin
        mem_req       = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        access_type   = DiatRead;
        if_done       = 1'b0;
        ls_done       = 1'b0;
        ls_misaligned = 1'b0;
        case (state)
            IfRd, LsRd, RmwRd: begin
                mem_req  = 1'b1;
                mem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
            end
            RmwWr, LsWr: begin
                mem_req     = 1'b1;
                mem_addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                mem_wdata   = wdata_q;
                access_type = DiatWrite;
            end
            Resp: begin
                if_done = client_if_q;
                ls_done = !client_if_q;
            end
            Reject:  ls_misaligned = 1'b1;
            default: ;
        endcase
    end

    assign mem_access_type = access_type;
    assign if_rdata        = if_rdata_q;
    assign ls_rdata        = ls_rdata_q;

endmodule

// File: tb/tb_mem_requester.sv
// Self-checking bench for mem_requester: a word-wide memory model with
// injectable read stalls, a vector table, corner sequences and random traffic.
module tb_mem_requester;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic [1:0]  ls_size;
    logic        if_done, ls_done, ls_misaligned;
    logic [31:0] if_rdata, ls_rdata;
    logic        mem_req, mem_access_type, mem_wait;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem_array [64];
    logic [31:0] ref_mem   [64];

    assign mem_rdata = mem_array[mem_addr[7:2]];

    mem_requester dut (
        .clk             (clk),
        .rst             (rst),
        .if_req          (if_req),
        .if_addr         (if_addr),
        .if_done         (if_done),
        .if_rdata        (if_rdata),
        .ls_req          (ls_req),
        .ls_we           (ls_we),
        .ls_size         (ls_size),
        .ls_addr         (ls_addr),
        .ls_wdata        (ls_wdata),
        .ls_done         (ls_done),
        .ls_rdata        (ls_rdata),
        .ls_misaligned   (ls_misaligned),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_access_type (mem_access_type),
        .mem_rdata       (mem_rdata),
        .mem_wait        (mem_wait)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Per-transaction observation log; cycle 0 is the cycle req is first raised.
    int          cyc, stall_left, n_req, n_wr, pulses;
    int          if_done_cyc, ls_done_cyc, mis_cyc;
    logic [31:0] got_if, got_ls;
    logic        req_at  [64];
    logic        we_at   [64];
    logic [31:0] addr_at [64];
    logic [31:0] wd_at   [64];

    task automatic clear_log();
        cyc = 0; n_req = 0; n_wr = 0; pulses = 0;
        if_done_cyc = -1; ls_done_cyc = -1; mis_cyc = -1;
        got_if = '0; got_ls = '0;
        for (int i = 0; i < 64; i++) begin
            req_at[i] = 1'b0; we_at[i] = 1'b0; addr_at[i] = '0; wd_at[i] = '0;
        end
    endtask

    // One clock cycle: observe at the falling edge, play the memory and the
    // clients (writes commit, reads may stall, req drops after its pulse).
    task automatic cycle();
        @(negedge clk);
        cyc++;
        mem_wait = 1'b0;
        if (mem_req) begin
            n_req++;
            if (cyc < 64) begin
                req_at[cyc] = 1'b1; we_at[cyc] = mem_access_type;
                addr_at[cyc] = mem_addr; wd_at[cyc] = mem_wdata;
            end
            if (mem_access_type) begin
                n_wr++;
                mem_array[mem_addr[7:2]] = mem_wdata;
            end else if (stall_left > 0) begin
                mem_wait = 1'b1;
                stall_left--;
            end
        end
        if (if_done) begin
            if (if_done_cyc < 0) if_done_cyc = cyc;
            got_if = if_rdata; if_req = 1'b0; pulses++;
        end
        if (ls_done) begin
            if (ls_done_cyc < 0) ls_done_cyc = cyc;
            got_ls = ls_rdata; ls_req = 1'b0; pulses++;
        end
        if (ls_misaligned) begin
            if (mis_cyc < 0) mis_cyc = cyc;
            ls_req = 1'b0; pulses++;
        end
    endtask

    task automatic run_to_idle();
        int guard = 0;
        while ((if_req || ls_req) && guard < 40) begin
            cycle();
            guard++;
        end
        if (if_req || ls_req) begin
            n_vec++; n_fail++;
            $display("FAIL timeout: request still pending after %0d cycles", guard);
            if_req = 1'b0; ls_req = 1'b0;
        end
        cycle();
    endtask

    task automatic start_ls(input logic we, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input int stall);
        clear_log();
        stall_left = stall; mem_wait = 1'b0;
        ls_we = we; ls_size = size; ls_addr = addr; ls_wdata = wdata; ls_req = 1'b1;
    endtask

    task automatic start_if(input logic [31:0] addr, input int stall);
        clear_log();
        stall_left = stall; mem_wait = 1'b0;
        if_addr = addr; if_req = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {27'b0, if_done, ls_done, ls_misaligned, mem_req, mem_access_type}, 32'h0);
        check({tag, "_addr"}, mem_addr, 32'h0);
        check({tag, "_wdata"}, mem_wdata, 32'h0);
        check({tag, "_rdata"}, if_rdata | ls_rdata, 32'h0);
    endtask

    // Reference model: big-endian lanes computed with plain shifts and masks.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input int sz, input int off);
        case (sz)
            0:       return (w >> (8 * (3 - off))) & 32'hFF;
            1:       return (w >> (16 * (1 - off / 2))) & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] wd,
                                              input int sz, input int off);
        int          sh;
        logic [31:0] m;
        case (sz)
            0:       begin sh = 8 * (3 - off);       m = 32'hFF << sh;   end
            1:       begin sh = 16 * (1 - off / 2);  m = 32'hFFFF << sh; end
            default: return wd;
        endcase
        return (w & ~m) | ((wd << sh) & m);
    endfunction

    function automatic logic ref_mis(input int sz, input int off);
        if (sz == 1) return (off % 2) != 0;
        if (sz == 2) return off != 0;
        return 1'b0;
    endfunction

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init_word;
        int          stall;
        logic        exp_mis;
        logic [31:0] exp_rdata;
        logic [31:0] exp_word;
        int          exp_lat;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [31:0] a, wd;
        int          sz, off, st, lat, idx;
        logic        we, mis;

        vecs[0]  = '{1'b0, 2'd0, 32'h12, 32'h0,        32'h11223344, 0, 1'b0, 32'h33,       32'h11223344, 2};
        vecs[1]  = '{1'b0, 2'd1, 32'h16, 32'h0,        32'h11223344, 0, 1'b0, 32'h3344,     32'h11223344, 2};
        vecs[2]  = '{1'b0, 2'd1, 32'h14, 32'h0,        32'hCAFEF00D, 0, 1'b0, 32'hCAFE,     32'hCAFEF00D, 2};
        vecs[3]  = '{1'b0, 2'd3, 32'h18, 32'h0,        32'h89ABCDEF, 0, 1'b0, 32'h89ABCDEF, 32'h89ABCDEF, 2};
        vecs[4]  = '{1'b1, 2'd1, 32'h22, 32'h1234,     32'hAABBCCDD, 0, 1'b0, 32'h0,        32'hAABB1234, 3};
        vecs[5]  = '{1'b1, 2'd0, 32'h24, 32'hFFFFFF5A, 32'h00000000, 0, 1'b0, 32'h0,        32'h5A000000, 3};
        vecs[6]  = '{1'b1, 2'd0, 32'h2B, 32'h77,       32'h11223344, 0, 1'b0, 32'h0,        32'h11223377, 3};
        vecs[7]  = '{1'b1, 2'd2, 32'h2C, 32'hCAFEBABE, 32'h00000000, 0, 1'b0, 32'h0,        32'hCAFEBABE, 2};
        vecs[8]  = '{1'b0, 2'd2, 32'h21, 32'h0,        32'h55555555, 0, 1'b1, 32'h0,        32'h55555555, 1};
        vecs[9]  = '{1'b1, 2'd1, 32'h27, 32'hBEEF,     32'h66666666, 0, 1'b1, 32'h0,        32'h66666666, 1};
        vecs[10] = '{1'b0, 2'd0, 32'h33, 32'h0,        32'hA1B2C3D4, 2, 1'b0, 32'hD4,       32'hA1B2C3D4, 4};
        vecs[11] = '{1'b1, 2'd1, 32'h34, 32'h9ABC,     32'h12345678, 1, 1'b0, 32'h0,        32'h9ABC5678, 4};
        vecs[12] = '{1'b0, 2'd2, 32'h38, 32'h0,        32'h0F0F0F0F, 3, 1'b0, 32'h0F0F0F0F, 32'h0F0F0F0F, 5};

        for (int i = 0; i < 64; i++) mem_array[i] = '0;
        rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'd0;
        if_addr = '0; ls_addr = '0; ls_wdata = '0; mem_wait = 1'b0; stall_left = 0;
        clear_log();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        cycle();

        // Word fetch: read at cycle 1, done at cycle 2.
        mem_array[4] = 32'hDEADBEEF;
        start_if(32'h10, 0);
        run_to_idle();
        check("fetch_req_c1", {31'b0, req_at[1]}, 32'h1);
        check("fetch_addr_c1", addr_at[1], 32'h10);
        check("fetch_is_read", {31'b0, we_at[1]}, 32'h0);
        check("fetch_done_cyc", if_done_cyc, 2);
        check("fetch_rdata", got_if, 32'hDEADBEEF);
        check("fetch_nreq", n_req, 1);

        foreach (vecs[i]) begin
            mem_array[vecs[i].addr[7:2]] = vecs[i].init_word;
            start_ls(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, vecs[i].stall);
            run_to_idle();
            lat = vecs[i].exp_mis ? mis_cyc : ls_done_cyc;
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_misaligned", i), {31'b0, mis_cyc >= 0}, {31'b0, vecs[i].exp_mis});
            check($sformatf("vec%0d_nreq", i), n_req, vecs[i].exp_lat - 1);
            check($sformatf("vec%0d_pulses", i), pulses, 1);
            check($sformatf("vec%0d_word", i), mem_array[vecs[i].addr[7:2]], vecs[i].exp_word);
            if (!vecs[i].we && !vecs[i].exp_mis)
                check($sformatf("vec%0d_rdata", i), got_ls, vecs[i].exp_rdata);
            if (vecs[i].exp_mis)
                check($sformatf("vec%0d_no_done", i), ls_done_cyc, -1);
        end

        // Half store RMW: read in cycle 1, merged write in cycle 2, done in cycle 3.
        mem_array[8] = 32'hAABBCCDD;
        start_ls(1'b1, 2'd1, 32'h22, 32'h1234, 0);
        run_to_idle();
        check("rmw_rd_c1", {30'b0, req_at[1], we_at[1]}, 32'h2);
        check("rmw_rd_addr", addr_at[1], 32'h20);
        check("rmw_wr_c2", {30'b0, req_at[2], we_at[2]}, 32'h3);
        check("rmw_wr_data", wd_at[2], 32'hAABB1234);
        check("rmw_done_cyc", ls_done_cyc, 3);
        check("rmw_nreq", n_req, 2);

        // Contention plus 2-cycle stall: load first, then fetch from Idle.
        mem_array[4]  = 32'h0BADF00D;
        mem_array[16] = 32'h600DCAFE;
        start_ls(1'b0, 2'd2, 32'h10, 32'h0, 2);
        if_addr = 32'h43; if_req = 1'b1;
        run_to_idle();
        check("cont_ls_done_cyc", ls_done_cyc, 4);
        check("cont_ls_rdata", got_ls, 32'h0BADF00D);
        lat = -1;
        for (int c = 63; c >= 1; c--) if (req_at[c] && addr_at[c] == 32'h40) lat = c;
        check("cont_fetch_req_cyc", lat, 6);
        check("cont_if_done_cyc", if_done_cyc, 7);
        check("cont_if_rdata", got_if, 32'h600DCAFE);
        check("cont_nreq", n_req, 4);

        // Reset during RmwRd: the write must never happen.
        mem_array[12] = 32'h01020304;
        start_ls(1'b1, 2'd0, 32'h31, 32'hAB, 0);
        cycle();
        check("rstmid_rd_c1", {30'b0, req_at[1], we_at[1]}, 32'h2);
        rst = 1'b1; ls_req = 1'b0;
        cycle();
        check_all_zero("rstmid");
        rst = 1'b0;
        repeat (3) cycle();
        check("rstmid_no_write", n_wr, 0);
        check("rstmid_mem", mem_array[12], 32'h01020304);

        // Random traffic against the reference model.
        for (int i = 0; i < 64; i++) begin
            ref_mem[i]   = $urandom;
            mem_array[i] = ref_mem[i];
        end
        for (int n = 0; n < 200; n++) begin
            a   = 32'($urandom_range(0, 255));
            st  = $urandom_range(0, 2);
            off = int'(a[1:0]);
            idx = int'(a[7:2]);
            if ($urandom_range(0, 3) == 0) begin
                start_if(a, st);
                run_to_idle();
                check($sformatf("rnd%0d_if_latency", n), if_done_cyc, 2 + st);
                check($sformatf("rnd%0d_if_rdata", n), got_if, ref_mem[idx]);
            end else begin
                we  = 1'($urandom_range(0, 1));
                sz  = $urandom_range(0, 3);
                wd  = $urandom;
                start_ls(we, 2'(sz), a, wd, st);
                run_to_idle();
                if (sz == 3) sz = 2;
                mis = ref_mis(sz, off);
                if (mis)         lat = 1;
                else if (!we)    lat = 2 + st;
                else if (sz == 2) lat = 2;
                else             lat = 3 + st;
                check($sformatf("rnd%0d_ls_latency", n), mis ? mis_cyc : ls_done_cyc, lat);
                check($sformatf("rnd%0d_ls_mis", n), {31'b0, mis_cyc >= 0}, {31'b0, mis});
                if (!we && !mis)
                    check($sformatf("rnd%0d_ls_rdata", n), got_ls, ref_load(ref_mem[idx], sz, off));
                if (we && !mis)
                    ref_mem[idx] = ref_store(ref_mem[idx], wd, sz, off);
                check($sformatf("rnd%0d_mem", n), mem_array[idx], ref_mem[idx]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
